logic_bist: RTL

Built-in self-test engine for the 4-bit logic unit (AND, OR, XOR gate blocks). It drives exhaustive operand pairs into the gate blocks and checks their outputs against an internal golden model, one vector per clock. It reports pass/fail, a failure count and per-operation failure flags. It sits beside the ALU and is started by the control unit or a debug strap.

---
 rtl/logic_bist_pkg.sv | 16 +
 rtl/logic_bist_ref.sv | 16 +
 rtl/logic_bist.sv | 123 ++++++++++++
 3 files changed

// File: rtl/logic_bist_pkg.sv
// rtl/logic_bist_pkg.sv - shared types and constants for the logic unit BIST engine
package logic_bist_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam int FLAG_AND = 0;
  localparam int FLAG_OR  = 1;
  localparam int FLAG_XOR = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/logic_bist_ref.sv
// rtl/logic_bist_ref.sv - combinational golden model of the AND/OR/XOR gate blocks
module logic_bist_ref #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] exp_and,
  output logic [WIDTH-1:0] exp_or,
  output logic [WIDTH-1:0] exp_xor
);

  assign exp_and = a & b;
  assign exp_or  = a | b;
  assign exp_xor = a ^ b;

endmodule

// File: rtl/logic_bist.sv
// rtl/logic_bist.sv - exhaustive BIST for the logic unit; BIST_FIRST_FAIL_EN adds first-fail capture
module logic_bist
  import logic_bist_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  input  logic [WIDTH-1:0]     and_in,
  input  logic [WIDTH-1:0]     or_in,
  input  logic [WIDTH-1:0]     xor_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     fail_count,
`ifdef BIST_FIRST_FAIL_EN
  output logic [2*WIDTH-1:0]   first_fail_vec,
  output logic                 first_fail_valid,
`endif
  output logic [2:0]           fail_flags
);

  localparam int VW = 2 * WIDTH;
  localparam logic [VW-1:0] LAST_VEC = '1;
  localparam logic [VW-1:0] VEC_ONE  = 1;
  localparam logic [VW:0]   CNT_ONE  = 1;

  state_t          state;
  state_t          state_nx;
  logic            start_run;
  logic [VW-1:0]   vec;
  logic [WIDTH-1:0] exp_and;
  logic [WIDTH-1:0] exp_or;
  logic [WIDTH-1:0] exp_xor;
  logic [2:0]      mism;

  // The vector counter is itself the operand register pair.
  assign op_a = vec[WIDTH-1:0];
  assign op_b = vec[VW-1:WIDTH];

  logic_bist_ref #(.WIDTH(WIDTH)) u_ref (
    .a       (op_a),
    .b       (op_b),
    .exp_and (exp_and),
    .exp_or  (exp_or),
    .exp_xor (exp_xor)
  );

  // Case inequality so an undriven or X gate output counts as a failure.
  assign mism[FLAG_AND] = (and_in !== exp_and);
  assign mism[FLAG_OR]  = (or_in  !== exp_or);
  assign mism[FLAG_XOR] = (xor_in !== exp_xor);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    start_run = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx  = RUN;
          start_run = 1'b1;
        end
      end
      RUN: begin
        if (vec == LAST_VEC) begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (fail_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec        <= '0;
      fail_count <= '0;
      fail_flags <= '0;
    end else if (start_run) begin
      vec        <= '0;
      fail_count <= '0;
      fail_flags <= '0;
    end else if (state == RUN) begin
      if (|mism) begin
        fail_count <= fail_count + CNT_ONE;
      end
      fail_flags <= fail_flags | mism;
      if (vec != LAST_VEC) begin
        vec <= vec + VEC_ONE;
      end
    end
  end

`ifdef BIST_FIRST_FAIL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (start_run) begin
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if ((state == RUN) && (|mism) && !first_fail_valid) begin
      first_fail_vec   <= vec;
      first_fail_valid <= 1'b1;
    end
  end
`endif

endmodule
